ps2_key_event_engine: RTL and testbench

- Parametrised successor to the single-byte make-code path: consumes raw scan-code bytes from ps2_keyboard through its ready/nextdata_n handshake.
- Decodes E0 (extended) and F0 (break) prefixes, tracks modifier state and currently held keys, optionally suppresses typematic repeats, and counts presses.
- Queues complete key events in a first-word-fall-through FIFO with a valid/ack handshake. Sits between ps2_keyboard and the ASCII/display logic.

---
 rtl/ps2_key_event_engine.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_key_event_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_engine.sv
// PS/2 scan-code event engine: decodes E0/F0 prefixes, tracks held keys and
// modifiers, and queues 13-bit key events in a first-word-fall-through FIFO.
module ps2_key_event_engine #(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_KEYS   = 6,
  parameter int CNT_WIDTH  = 8,
  parameter int REPEAT_EN  = 0
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_overflow,
  output logic                 rx_nextdata_n,
  output logic                 ev_valid,
  output logic [12:0]          ev_data,
  input  logic                 ev_ack,
  output logic                 shift,
  output logic                 ctrl,
  output logic                 caps,
  output logic [3:0]           held_count,
  output logic [CNT_WIDTH-1:0] press_count,
  output logic                 ev_drop,
  output logic                 rx_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DEC  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t               r_state;
  logic [7:0]           r_byte;
  logic                 r_ext;
  logic                 r_brk;
  logic                 r_nd_n;
  logic [MAX_KEYS-1:0]  r_vld;
  logic [8:0]           r_key [MAX_KEYS];
  logic                 r_shift;
  logic                 r_ctrl;
  logic                 r_caps;
  logic [3:0]           r_held_cnt;
  logic [CNT_WIDTH-1:0] r_press;
  logic                 r_drop;
  logic                 r_ovf;
  logic [12:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_cnt;

  logic [8:0]           w_key_in;
  logic                 w_is_prefix;
  logic                 w_dec_evt;
  logic [MAX_KEYS-1:0]  w_match;
  logic [MAX_KEYS-1:0]  w_ins;
  logic                 w_hit;
  logic                 w_seen_free;
  logic                 w_make_new;
  logic [MAX_KEYS-1:0]  w_vld_n;
  logic [8:0]           w_key_n [MAX_KEYS];
  logic                 w_shift_n;
  logic                 w_ctrl_n;
  logic                 w_caps_n;
  logic [3:0]           w_held_cnt_n;
  logic                 w_emit;
  logic [12:0]          w_evt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push_ok;

  assign w_key_in    = {r_ext, r_byte};
  assign w_is_prefix = (r_byte == 8'hE0) || (r_byte == 8'hF0);
  assign w_dec_evt   = (r_state == S_DEC) && !w_is_prefix;
  // A make for a key already held is a typematic repeat.
  assign w_emit      = r_brk || !w_hit || (REPEAT_EN != 0);
  assign w_caps_n    = r_caps ^ (w_make_new && (r_byte == 8'h58));
  assign w_evt       = {w_caps_n, w_ctrl_n, w_shift_n, r_brk, r_ext, r_byte};
  assign w_push      = w_dec_evt && w_emit;
  assign w_pop       = ev_ack && (r_cnt != '0);
  assign w_full      = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_push_ok   = w_push && (!w_full || w_pop);

  assign rx_nextdata_n = r_nd_n;
  assign ev_valid      = (r_cnt != '0);
  assign ev_data       = r_mem[r_rptr];
  assign shift         = r_shift;
  assign ctrl          = r_ctrl;
  assign caps          = r_caps;
  assign held_count    = r_held_cnt;
  assign press_count   = r_press;
  assign ev_drop       = r_drop;
  assign rx_ovf        = r_ovf;

  // Next held-table contents and the modifiers derived from them.
  always_comb begin
    w_match      = '0;
    w_ins        = '0;
    w_hit        = 1'b0;
    w_seen_free  = 1'b0;
    w_vld_n      = '0;
    w_key_n      = r_key;
    w_shift_n    = 1'b0;
    w_ctrl_n     = 1'b0;
    w_held_cnt_n = 4'd0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      w_match[i] = r_vld[i] && (r_key[i] == w_key_in);
      w_hit      = w_hit | w_match[i];
    end
    w_make_new = !r_brk && !w_hit;
    for (int i = 0; i < MAX_KEYS; i++) begin
      w_ins[i]     = w_make_new && !r_vld[i] && !w_seen_free;
      w_seen_free  = w_seen_free | !r_vld[i];
      w_vld_n[i]   = (r_vld[i] && !(r_brk && w_match[i])) || w_ins[i];
      w_key_n[i]   = w_ins[i] ? w_key_in : r_key[i];
      w_shift_n    = w_shift_n | (w_vld_n[i] &&
                     ((w_key_n[i] == 9'h012) || (w_key_n[i] == 9'h059)));
      w_ctrl_n     = w_ctrl_n | (w_vld_n[i] && (w_key_n[i][7:0] == 8'h14));
      w_held_cnt_n = w_held_cnt_n + 4'(w_vld_n[i]);
    end
  end

  // Byte handshake FSM plus prefix, held-table, modifier and counter state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_byte     <= 8'h00;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_nd_n     <= 1'b1;
      r_vld      <= '0;
      for (int i = 0; i < MAX_KEYS; i++) r_key[i] <= 9'h000;
      r_shift    <= 1'b0;
      r_ctrl     <= 1'b0;
      r_caps     <= 1'b0;
      r_held_cnt <= 4'd0;
      r_press    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_ready) begin
            r_byte  <= rx_data;
            r_nd_n  <= 1'b0;
            r_state <= S_DEC;
          end else begin
            r_nd_n  <= 1'b1;
          end
        end
        S_DEC: begin
          r_nd_n  <= 1'b1;
          r_state <= S_WAIT;
          if (r_byte == 8'hE0) begin
            r_ext <= 1'b1;
          end else if (r_byte == 8'hF0) begin
            r_brk <= 1'b1;
          end else begin
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_vld      <= w_vld_n;
            r_key      <= w_key_n;
            r_shift    <= w_shift_n;
            r_ctrl     <= w_ctrl_n;
            r_caps     <= w_caps_n;
            r_held_cnt <= w_held_cnt_n;
            if (w_make_new) r_press <= r_press + CNT_WIDTH'(1);
          end
        end
        S_WAIT: begin
          r_nd_n  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_nd_n  <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Event FIFO; a push into a full FIFO survives only if the head pops too.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 13'h0000;
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= w_evt;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_push && !w_push_ok) r_drop <= 1'b1;
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop) begin
        r_cnt <= r_cnt + (AW+1)'(1);
      end else if (!w_push_ok && w_pop) begin
        r_cnt <= r_cnt - (AW+1)'(1);
      end
    end
  end

  // Sticky receiver-overflow flag.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_ovf <= 1'b0;
    end else if (rx_overflow) begin
      r_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_engine.sv
// Bench for ps2_key_event_engine: two instances (default, and REPEAT_EN=1 with a
// 4-deep FIFO) share one byte stream; events are checked through scoreboards.
module tb_ps2_key_event_engine;

  logic clk = 1'b0, clr = 1'b1, rx_ready = 1'b0, rx_overflow = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic nd0, nd1, v0, v1, ack0 = 1'b0, ack1 = 1'b0;
  logic [12:0] d0, d1;
  logic sh0, ct0, cp0, sh1, ct1, cp1, dr0, dr1, ov0, ov1;
  logic [3:0] hc0, hc1;
  logic [7:0] pc0, pc1;

  int total = 0, bad = 0;
  logic [12:0] q0[$], q1[$];
  int low_cyc = 0, pulses = 0;
  logic nd_prev = 1'b1;

  typedef struct packed {
    logic [7:0]  b;
    logic        e0;
    logic [12:0] x0;
    logic        e1;
    logic [12:0] x1;
    logic [7:0]  pc;
    logic [3:0]  hc;
  } vec_t;
  vec_t tv [27];

  always #5 clk = ~clk;

  ps2_key_event_engine dut0 (
    .clk(clk), .clr(clr), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_overflow(rx_overflow), .rx_nextdata_n(nd0), .ev_valid(v0), .ev_data(d0),
    .ev_ack(ack0), .shift(sh0), .ctrl(ct0), .caps(cp0), .held_count(hc0),
    .press_count(pc0), .ev_drop(dr0), .rx_ovf(ov0));

  ps2_key_event_engine #(.FIFO_DEPTH(4), .REPEAT_EN(1)) dut1 (
    .clk(clk), .clr(clr), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_overflow(rx_overflow), .rx_nextdata_n(nd1), .ev_valid(v1), .ev_data(d1),
    .ev_ack(ack1), .shift(sh1), .ctrl(ct1), .caps(cp1), .held_count(hc1),
    .press_count(pc1), .ev_drop(dr1), .rx_ovf(ov1));

  always @(negedge clk) begin
    if (!clr) begin
      if (nd0 === 1'b0) low_cyc <= low_cyc + 1;
      if (nd0 === 1'b0 && nd_prev === 1'b1) pulses <= pulses + 1;
      nd_prev <= nd0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] b, input logic e, input logic [12:0] x,
                              input logic [7:0] pc, input logic [3:0] hc);
    return '{b, e, x, e, x, pc, hc};
  endfunction

  // Offer one byte; optionally ack dut1's head in the cycle its DEC push lands.
  // Returns at the falling edge after the DEC cycle.
  task automatic send(input logic [7:0] b, input bit ack1_dec);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    while (nd0 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", 32'(nd0 === 1'b0), 32'd1);
    rx_ready = 1'b0;
    if (ack1_dec) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL ack_head: got %h expected nothing queued", d1);
      end else begin
        chk("ack_head", 32'(d1), 32'(q1.pop_front()));
      end
      ack1 = 1'b1;
    end
    @(negedge clk);
    ack1 = 1'b0;
  endtask

  task automatic drain(input bit which);
    int g = 0;
    logic [12:0] e;
    while ((which ? v1 : v0) === 1'b1 && g < 16) begin
      if ((which ? q1.size() : q0.size()) == 0) begin
        total++; bad++;
        $display("FAIL extra_event dut%0d: got %h expected none", which, which ? d1 : d0);
      end else begin
        if (which) e = q1.pop_front(); else e = q0.pop_front();
        chk(which ? "event_dut1" : "event_dut0", 32'(which ? d1 : d0), 32'(e));
      end
      if (which) ack1 = 1'b1; else ack0 = 1'b1;
      @(negedge clk);
      ack0 = 1'b0;
      ack1 = 1'b0;
      g++;
    end
    chk(which ? "leftover_dut1" : "leftover_dut0", 32'(which ? q1.size() : q0.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] fb [6];
    tv[0]  = mk(8'h1C, 1'b1, 13'h001C, 8'd1, 4'd1);
    tv[1]  = mk(8'hF0, 1'b0, 13'h0000, 8'd1, 4'd1);
    tv[2]  = mk(8'h1C, 1'b1, 13'h021C, 8'd1, 4'd0);
    tv[3]  = mk(8'hE0, 1'b0, 13'h0000, 8'd1, 4'd0);
    tv[4]  = mk(8'h75, 1'b1, 13'h0175, 8'd2, 4'd1);
    tv[5]  = mk(8'hE0, 1'b0, 13'h0000, 8'd2, 4'd1);
    tv[6]  = mk(8'hF0, 1'b0, 13'h0000, 8'd2, 4'd1);
    tv[7]  = mk(8'h75, 1'b1, 13'h0375, 8'd2, 4'd0);
    tv[8]  = mk(8'h12, 1'b1, 13'h0412, 8'd3, 4'd1);
    tv[9]  = mk(8'h1C, 1'b1, 13'h041C, 8'd4, 4'd2);
    tv[10] = mk(8'h58, 1'b1, 13'h1458, 8'd5, 4'd3);
    tv[11] = mk(8'hF0, 1'b0, 13'h0000, 8'd5, 4'd3);
    tv[12] = mk(8'h58, 1'b1, 13'h1658, 8'd5, 4'd2);
    tv[13] = mk(8'h58, 1'b1, 13'h0458, 8'd6, 4'd3);
    tv[14] = '{8'h1C, 1'b0, 13'h0000, 1'b1, 13'h041C, 8'd6, 4'd3};
    tv[15] = '{8'h1C, 1'b0, 13'h0000, 1'b1, 13'h041C, 8'd6, 4'd3};
    tv[16] = mk(8'hF0, 1'b0, 13'h0000, 8'd6, 4'd3);
    tv[17] = mk(8'h1C, 1'b1, 13'h061C, 8'd6, 4'd2);
    tv[18] = mk(8'hF0, 1'b0, 13'h0000, 8'd6, 4'd2);
    tv[19] = mk(8'h12, 1'b1, 13'h0212, 8'd6, 4'd1);
    tv[20] = mk(8'hF0, 1'b0, 13'h0000, 8'd6, 4'd1);
    tv[21] = mk(8'h58, 1'b1, 13'h0258, 8'd6, 4'd0);
    tv[22] = mk(8'hE0, 1'b0, 13'h0000, 8'd6, 4'd0);
    tv[23] = mk(8'h14, 1'b1, 13'h0914, 8'd7, 4'd1);
    tv[24] = mk(8'hE0, 1'b0, 13'h0000, 8'd7, 4'd1);
    tv[25] = mk(8'hF0, 1'b0, 13'h0000, 8'd7, 4'd1);
    tv[26] = mk(8'h14, 1'b1, 13'h0314, 8'd7, 4'd0);
    fb = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_nextdata_n", 32'(nd0), 32'd1);
    chk("rst_ev_valid", 32'(v0), 32'd0);
    chk("rst_ev_data", 32'(d0), 32'd0);
    chk("rst_press", 32'(pc0), 32'd0);
    chk("rst_held", 32'(hc0), 32'd0);
    chk("rst_flags", 32'({dr0, ov0, sh0, ct0, cp0}), 32'd0);
    @(negedge clk);
    clr = 1'b0;

    for (int i = 0; i < 27; i++) begin
      if (tv[i].e0) q0.push_back(tv[i].x0);
      if (tv[i].e1) q1.push_back(tv[i].x1);
      send(tv[i].b, 1'b0);
      chk("latency_valid0", 32'(v0), 32'(tv[i].e0));
      chk("latency_valid1", 32'(v1), 32'(tv[i].e1));
      chk("press0", 32'(pc0), 32'(tv[i].pc));
      chk("press1", 32'(pc1), 32'(tv[i].pc));
      chk("held0", 32'(hc0), 32'(tv[i].hc));
      chk("held1", 32'(hc1), 32'(tv[i].hc));
      if (i == 8)  chk("shift_live", 32'(sh0), 32'd1);
      if (i == 10) chk("caps_live", 32'(cp0), 32'd1);
      if (i == 23) chk("ctrl_live", 32'(ct1), 32'd1);
      drain(1'b0);
      drain(1'b1);
    end
    chk("strobe_pulses", 32'(pulses), 32'd27);
    chk("strobe_low_cycles", 32'(low_cyc), 32'd27);

    // FIFO overflow on the 4-deep instance, then a same-cycle pop+push when full.
    for (int k = 0; k < 5; k++) begin
      q0.push_back({5'b00000, fb[k]});
      if (k < 4) q1.push_back({5'b00000, fb[k]});
      send(fb[k], 1'b0);
      if (k == 3) chk("drop_before_full", 32'(dr1), 32'd0);
    end
    chk("drop_when_full", 32'(dr1), 32'd1);
    chk("no_drop_deep", 32'(dr0), 32'd0);
    q0.push_back({5'b00000, fb[5]});
    q1.push_back({5'b00000, fb[5]});
    send(fb[5], 1'b1);
    chk("full_valid", 32'(v1), 32'd1);
    chk("press_after_fifo", 32'(pc0), 32'd13);
    chk("held_after_fifo", 32'(hc0), 32'd6);
    drain(1'b0);
    drain(1'b1);

    // Sticky overflow, then asynchronous reset in the middle of DEC.
    @(negedge clk);
    rx_overflow = 1'b1;
    @(negedge clk);
    rx_overflow = 1'b0;
    chk("rx_ovf_set", 32'({ov0, ov1}), 32'd3);
    send(8'h43, 1'b0);
    chk("pending_valid", 32'(v0), 32'd1);
    @(negedge clk);
    rx_data  = 8'h3C;
    rx_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (nd0 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_dec_strobe", 32'(nd0), 32'd0);
    rx_ready = 1'b0;
    #1 clr = 1'b1;
    #1;
    chk("clr_nextdata_n", 32'(nd0), 32'd1);
    chk("clr_valid", 32'({v0, v1}), 32'd0);
    chk("clr_data", 32'(d0), 32'd0);
    chk("clr_counts", 32'({pc0, hc0}), 32'd0);
    chk("clr_flags", 32'({dr1, ov0, sh0, ct0, cp0}), 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("no_event_after_clr", 32'({v0, v1}), 32'd0);
    chk("press_after_clr", 32'(pc0), 32'd0);
    q0.delete();
    q1.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
